// File: rtl/ascii_dec_to_bin.sv
// ASCII decimal field parser: digits -> 12-bit unsigned value, committed on a terminator.
// Optional build macro ASCII_DEC_SKIP_SPACE_EN: ignore leading spaces in a field.
module ascii_dec_to_bin #(
  parameter int         MAX_DIGITS = 4,
  parameter logic [7:0] TERMINATOR = 8'h0D
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] value,
  output logic        value_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CODE_BAD   = 2'd1;
  localparam logic [1:0] CODE_OVF   = 2'd2;
  localparam logic [1:0] CODE_EMPTY = 2'd3;

  state_t      state_reg, state_next;
  logic [15:0] acc_reg, acc_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        bad_reg, bad_next;
  logic        ovf_reg, ovf_next;
  logic [3:0]  digit_reg, digit_next;
  logic [11:0] value_reg, value_next;
  logic        value_valid_reg, value_valid_next;
  logic        err_reg, err_next;
  logic [1:0]  err_code_reg, err_code_next;

  logic        take;
  logic        is_digit;
  logic        is_term;
  logic        skip_space;
  logic        too_many;
  logic        reject_digit;
  logic [2:0]  cnt_inc;
  logic [15:0] sum;

  assign take     = char_valid && (state_reg == IDLE);
  assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_term  = (char_in == TERMINATOR);
  assign cnt_inc  = (cnt_reg == 3'd7) ? 3'd7 : cnt_reg + 3'd1;
  assign too_many = (int'(cnt_reg) + 1) > MAX_DIGITS;
  assign sum      = acc_reg + {12'd0, digit_reg};

  // A digit that cannot extend the field is still consumed, only flagged.
  assign reject_digit = bad_reg || ovf_reg || too_many;

`ifdef ASCII_DEC_SKIP_SPACE_EN
  assign skip_space = (char_in == 8'h20) && (cnt_reg == 3'd0) && !bad_reg && !ovf_reg;
`else
  assign skip_space = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            if (!reject_digit) state_next = SCALE;
          end else if (is_term) begin
            state_next = DONE;
          end
        end
      end
      SCALE:   state_next = ADD;
      ADD:     state_next = IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    acc_next         = acc_reg;
    cnt_next         = cnt_reg;
    bad_next         = bad_reg;
    ovf_next         = ovf_reg;
    digit_next       = digit_reg;
    value_next       = value_reg;
    value_valid_next = 1'b0;
    err_next         = 1'b0;
    err_code_next    = 2'd0;
    case (state_reg)
      IDLE: begin
        if (take) begin
          if (is_digit) begin
            cnt_next = cnt_inc;
            if (reject_digit) begin
              if (!bad_reg) ovf_next = 1'b1;
            end else begin
              digit_next = char_in[3:0];
            end
          end else if (is_term) begin
            // field ends; evaluated in DONE
          end else if (!skip_space) begin
            bad_next = 1'b1;
          end
        end
      end
      SCALE: begin
        acc_next = (acc_reg << 3) + (acc_reg << 1);
      end
      ADD: begin
        acc_next = sum;
        if (sum > 16'd4095) ovf_next = 1'b1;
      end
      DONE: begin
        if (bad_reg) begin
          err_next      = 1'b1;
          err_code_next = CODE_BAD;
        end else if (ovf_reg) begin
          err_next      = 1'b1;
          err_code_next = CODE_OVF;
        end else if (cnt_reg == 3'd0) begin
          err_next      = 1'b1;
          err_code_next = CODE_EMPTY;
        end else begin
          value_next       = acc_reg[11:0];
          value_valid_next = 1'b1;
        end
        acc_next = 16'd0;
        cnt_next = 3'd0;
        bad_next = 1'b0;
        ovf_next = 1'b0;
      end
      default: begin
        acc_next = 16'd0;
        cnt_next = 3'd0;
        bad_next = 1'b0;
        ovf_next = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg         <= 16'd0;
      cnt_reg         <= 3'd0;
      bad_reg         <= 1'b0;
      ovf_reg         <= 1'b0;
      digit_reg       <= 4'd0;
      value_reg       <= 12'd0;
      value_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      err_code_reg    <= 2'd0;
    end else begin
      acc_reg         <= acc_next;
      cnt_reg         <= cnt_next;
      bad_reg         <= bad_next;
      ovf_reg         <= ovf_next;
      digit_reg       <= digit_next;
      value_reg       <= value_next;
      value_valid_reg <= value_valid_next;
      err_reg         <= err_next;
      err_code_reg    <= err_code_next;
    end
  end

  assign char_ready  = (state_reg == IDLE);
  assign value       = value_reg;
  assign value_valid = value_valid_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_ascii_dec_to_bin.sv
// Directed bench for ascii_dec_to_bin; expected results are hand-computed per field.
module tb_ascii_dec_to_bin;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] value;
  logic        value_valid;
  logic        err;
  logic [1:0]  err_code;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int vv_cnt = 0;
  int err_cnt = 0;
  int last_code = 0;
  int code_leak = 0;
  int xfer_cyc  = 0;

  ascii_dec_to_bin dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (value_valid) vv_cnt <= vv_cnt + 1;
    if (err) begin
      err_cnt   <= err_cnt + 1;
      last_code <= int'(err_code);
    end else if (err_code != 2'd0) begin
      code_leak <= code_leak + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the transfer edge.
  task automatic send(input logic [7:0] c, input bit gap);
    int k;
    if (gap) begin
      char_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    char_in    = c;
    char_valid = 1'b1;
    k = 0;
    while (!char_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k == 20) check("ready_timeout", 0, 1);
    @(posedge clk);
    xfer_cyc = cyc;
    #1;
  endtask

  task automatic run_field(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) send(s[i], gap);
    send(8'h0D, gap);
    char_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic field(input string tag, input string s, input int exp_vv,
                       input int exp_code, input int exp_value);
    int vv0, er0;
    vv0 = vv_cnt;
    er0 = err_cnt;
    run_field(s, 1'b0);
    check({tag, "_vv"}, vv_cnt - vv0, exp_vv);
    check({tag, "_err"}, err_cnt - er0, (exp_code != 0) ? 1 : 0);
    if (exp_code != 0) check({tag, "_code"}, last_code, exp_code);
    check({tag, "_value"}, int'(value), exp_value);
  endtask

  initial begin
    int t0, t1, vv0;
    string s;
    rst_ni     = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(char_ready), 1);
    check("rst_value", int'(value), 0);
    check("rst_vv", int'(value_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_code", int'(err_code), 0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // "1234" CR with valid held high; digit accept edges 3 cycles apart
    vv0 = vv_cnt;
    s = "1234";
    send(s[0], 1'b0);
    t0 = xfer_cyc;
    check("scale_ready_low", int'(char_ready), 0);
    for (int i = 1; i < 4; i++) begin
      send(s[i], 1'b0);
      t1 = xfer_cyc;
      check("digit_spacing", t1 - t0, 3);
      t0 = t1;
    end
    send(8'h0D, 1'b0);
    check("term_spacing", xfer_cyc - t0, 3);
    check("done_ready_low", int'(char_ready), 0);
    char_valid = 1'b0;
    @(posedge clk);
    #1;
    check("commit_vv_pulse", int'(value_valid), 1);
    check("commit_value_now", int'(value), 1234);
    check("commit_ready_back", int'(char_ready), 1);
    @(posedge clk);
    #1;
    check("commit_vv_one_cycle", int'(value_valid), 0);
    check("f1234_vv", vv_cnt - vv0, 1);

    field("f4095", "4095", 1, 0, 4095);
    field("f4096", "4096", 0, 2, 4095);
    field("f00042", "00042", 0, 2, 4095);
    field("f0007", "0007", 1, 0, 7);
    field("f12a3", "12a3", 0, 1, 7);
    field("fempty", "", 0, 3, 7);
`ifdef ASCII_DEC_SKIP_SPACE_EN
    field("fsp42", " 42", 1, 0, 42);
    field("f4sp2", "4 2", 0, 1, 42);
`else
    field("fsp42", " 42", 0, 1, 7);
    field("f4sp2", "4 2", 0, 1, 7);
`endif

    // Asynchronous reset mid-field after "98"
    vv0 = vv_cnt;
    t0  = err_cnt;
    send(8'h39, 1'b0);
    send(8'h38, 1'b0);
    char_valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", int'(char_ready), 1);
    check("mid_rst_value", int'(value), 0);
    check("mid_rst_vv", int'(value_valid), 0);
    check("mid_rst_err", int'(err), 0);
    #7;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_pulse", (vv_cnt - vv0) + (err_cnt - t0), 0);
    field("f5", "5", 1, 0, 5);

    // Randomised valid gaps
    vv0 = vv_cnt;
    t0  = err_cnt;
    run_field("3071", 1'b1);
    check("gap_value", int'(value), 3071);
    check("gap_vv", vv_cnt - vv0, 1);
    check("gap_err", err_cnt - t0, 0);

    check("code_idle_zero", code_leak, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
